thresholding_cfg_loader: RTL

//  AXI-lite initiator that bulk-loads a thresholding kernel's parameter memory over its AXI-lite config port.

---
 rtl/thresholding_cfg_loader_pkg.sv | 29 ++
 rtl/thresholding_cfg_addr_gen.sv | 79 +++++++
 rtl/thresholding_cfg_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/thresholding_cfg_loader_pkg.sv
// Shared types and helpers for the thresholding config loader.
//   state_e     : loader FSM states (read states only reachable with readback build)
//   AXI_OKAY    : AXI response code for a successful transfer
//   ext_thresh  : widens a WT-bit threshold to a 32-bit AXI-lite data word
package thresholding_cfg_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StResp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    // Bits at and above wt are filled with the threshold MSB (signed) or zero.
    function automatic logic [31:0] ext_thresh(input logic [31:0] d, input int unsigned wt,
                                               input bit signed_en);
        logic [31:0] upper;
        logic        msb;
        upper = (wt >= 32) ? 32'h0 : (32'hFFFF_FFFF << wt);
        msb   = |(d & (32'h1 << (wt - 1)));
        return (signed_en && msb) ? ((d & ~upper) | upper) : (d & ~upper);
    endfunction

endpackage

// File: rtl/thresholding_cfg_addr_gen.sv
// Nested cf/pe/t counters producing the AXI-lite byte address of the current threshold.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : zero all counters (start of a load)
//   inc_i         : advance to the next threshold (t inner, pe middle, cf outer)
//   addr_o        : {cf, pe, t, 2'b00}; empty fields dropped when CF or PE is 1
//   last_o        : counters sit on the final threshold of the load
module thresholding_cfg_addr_gen #(
    parameter int unsigned N  = 2,
    parameter int unsigned CF = 1,
    parameter int unsigned PE = 1,
    localparam int unsigned CfBits   = $clog2(CF),
    localparam int unsigned PeBits   = $clog2(PE),
    localparam int unsigned AddrBits = CfBits + PeBits + N + 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [AddrBits-1:0] addr_o,
    output logic                last_o
);

    localparam int unsigned CfW   = (CfBits > 0) ? CfBits : 1;
    localparam int unsigned PeW   = (PeBits > 0) ? PeBits : 1;
    localparam int unsigned WordW = AddrBits - 2;
    localparam int unsigned T     = (2 ** N) - 1;

    logic [CfW-1:0] cf_q, cf_d;
    logic [PeW-1:0] pe_q, pe_d;
    logic [N-1:0]   t_q, t_d;
    logic           t_last, pe_last, cf_last;
    logic [WordW-1:0] word;

    assign t_last  = (t_q == N'(T - 1));
    assign pe_last = (pe_q == PeW'(PE - 1));
    assign cf_last = (cf_q == CfW'(CF - 1));
    assign last_o  = t_last & pe_last & cf_last;

    always_comb begin
        cf_d = cf_q;
        pe_d = pe_q;
        t_d  = t_q;
        if (clr_i) begin
            cf_d = '0;
            pe_d = '0;
            t_d  = '0;
        end else if (inc_i) begin
            if (!t_last) begin
                t_d = t_q + N'(1);
            end else begin
                t_d = '0;
                if (!pe_last) begin
                    pe_d = pe_q + PeW'(1);
                end else begin
                    pe_d = '0;
                    cf_d = cf_last ? '0 : cf_q + CfW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cf_q <= '0;
            pe_q <= '0;
            t_q  <= '0;
        end else begin
            cf_q <= cf_d;
            pe_q <= pe_d;
            t_q  <= t_d;
        end
    end

    // An empty field keeps a 1-bit counter that stays at zero and shifts out of the word.
    assign word   = (WordW'(cf_q) << (PeBits + N)) | (WordW'(pe_q) << N) | WordW'(t_q);
    assign addr_o = {word, 2'b00};

endmodule

// File: rtl/thresholding_cfg_loader.sv
// AXI-lite initiator that streams thresholds into a thresholding kernel's parameter memory.
// One AXI-stream beat -> one single-beat AXI-lite write, channel-major order.
// Build option: define THRESHOLDING_CFG_LOADER_READBACK_EN to read back and verify every
// written word (adds AR/R ports and the RADDR/RDATA states).
// Ports:
//   ap_clk, ap_rst_n        : clock, async active-low reset
//   start / busy / done     : load control and status (done is a 1-cycle pulse)
//   err                     : sticky error, cleared by an accepted start
//   s_axis_t{ready,valid,data} : threshold stream, threshold in tdata[WT-1:0]
//   m_axilite_AW*/W*/B*     : AXI-lite write channels
//   m_axilite_AR*/R*        : AXI-lite read channels (readback build only)
module thresholding_cfg_loader
    import thresholding_cfg_loader_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned WT     = 8,
    parameter int unsigned C      = 1,
    parameter int unsigned PE     = 1,
    parameter bit          SIGNED = 1'b1,
    localparam int unsigned CF        = C / PE,
    localparam int unsigned DW        = ((WT + 7) / 8) * 8,
    localparam int unsigned ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tvalid,
    input  logic [DW-1:0]        s_axis_tdata,
    output logic                 m_axilite_AWVALID,
    input  logic                 m_axilite_AWREADY,
    output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
    output logic [2:0]           m_axilite_AWPROT,
    output logic                 m_axilite_WVALID,
    input  logic                 m_axilite_WREADY,
    output logic [31:0]          m_axilite_WDATA,
    output logic [3:0]           m_axilite_WSTRB,
    input  logic                 m_axilite_BVALID,
    output logic                 m_axilite_BREADY,
    input  logic [1:0]           m_axilite_BRESP
`ifdef THRESHOLDING_CFG_LOADER_READBACK_EN
    ,
    output logic                 m_axilite_ARVALID,
    input  logic                 m_axilite_ARREADY,
    output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
    output logic [2:0]           m_axilite_ARPROT,
    input  logic                 m_axilite_RVALID,
    output logic                 m_axilite_RREADY,
    input  logic [31:0]          m_axilite_RDATA,
    input  logic [1:0]           m_axilite_RRESP
`endif
);

    state_e          state_q, state_d;
    logic [WT-1:0]   data_q, data_d;
    logic            aw_ok_q, aw_ok_d;
    logic            w_ok_q, w_ok_d;
    logic            err_q, err_d;
    logic            cnt_clr, cnt_inc, cnt_last;
    logic            aw_done, w_done;

    thresholding_cfg_addr_gen #(
        .N  (N),
        .CF (CF),
        .PE (PE)
    ) u_addr_gen (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .addr_o (m_axilite_AWADDR),
        .last_o (cnt_last)
    );

    assign aw_done = aw_ok_q | (m_axilite_AWVALID & m_axilite_AWREADY);
    assign w_done  = w_ok_q  | (m_axilite_WVALID  & m_axilite_WREADY);

    always_comb begin
        state_d           = state_q;
        data_d            = data_q;
        aw_ok_d           = aw_ok_q;
        w_ok_d            = w_ok_q;
        err_d             = err_q;
        cnt_clr           = 1'b0;
        cnt_inc           = 1'b0;
        busy              = (state_q != StIdle);
        done              = (state_q == StDone);
        s_axis_tready     = (state_q == StFetch);
        m_axilite_AWVALID = (state_q == StWrite) && !aw_ok_q;
        m_axilite_WVALID  = (state_q == StWrite) && !w_ok_q;
        m_axilite_BREADY  = (state_q == StResp);
`ifdef THRESHOLDING_CFG_LOADER_READBACK_EN
        m_axilite_ARVALID = (state_q == StRaddr);
        m_axilite_RREADY  = (state_q == StRdata);
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                end
            end
            StFetch: begin
                if (s_axis_tvalid) begin
                    data_d  = s_axis_tdata[WT-1:0];
                    aw_ok_d = 1'b0;
                    w_ok_d  = 1'b0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Each channel's flag drops its valid independently of the other channel.
                if (m_axilite_AWVALID && m_axilite_AWREADY) aw_ok_d = 1'b1;
                if (m_axilite_WVALID && m_axilite_WREADY)   w_ok_d  = 1'b1;
                if (aw_done && w_done) state_d = StResp;
            end
            StResp: begin
                if (m_axilite_BVALID) begin
                    if (m_axilite_BRESP != AXI_OKAY) err_d = 1'b1;
`ifdef THRESHOLDING_CFG_LOADER_READBACK_EN
                    state_d = StRaddr;
`else
                    cnt_inc = 1'b1;
                    state_d = cnt_last ? StDone : StFetch;
`endif
                end
            end
`ifdef THRESHOLDING_CFG_LOADER_READBACK_EN
            StRaddr: begin
                if (m_axilite_ARREADY) state_d = StRdata;
            end
            StRdata: begin
                if (m_axilite_RVALID) begin
                    if ((m_axilite_RDATA[WT-1:0] != data_q) || (m_axilite_RRESP != AXI_OKAY)) begin
                        err_d = 1'b1;
                    end
                    cnt_inc = 1'b1;
                    state_d = cnt_last ? StDone : StFetch;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            aw_ok_q <= 1'b0;
            w_ok_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            aw_ok_q <= aw_ok_d;
            w_ok_q  <= w_ok_d;
            err_q   <= err_d;
        end
    end

    assign err              = err_q;
    assign m_axilite_AWPROT = 3'b000;
    assign m_axilite_WSTRB  = 4'hF;
    assign m_axilite_WDATA  = ext_thresh(32'(data_q), WT, SIGNED);

`ifdef THRESHOLDING_CFG_LOADER_READBACK_EN
    assign m_axilite_ARADDR = m_axilite_AWADDR;
    assign m_axilite_ARPROT = 3'b000;
    if (WT < 32) begin : g_unused_rdata
        logic unused_rdata;
        assign unused_rdata = ^m_axilite_RDATA[31:WT];
    end
`endif

    // Stream bytes above the threshold width carry no information.
    if (DW > WT) begin : g_unused_tdata
        logic unused_tdata;
        assign unused_tdata = ^s_axis_tdata[DW-1:WT];
    end

endmodule
